// File: rtl/imem_loader_if.sv
// Stream-in / byte-write-out bus of the instruction memory loader.
// The slave side is the loader. The master side is the word source, which also observes the memory write port.
interface imem_loader_if #(
  parameter int ADDR_W = 9
);
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Loads 32-bit program words into the byte-wide big-endian instruction memory.
// Each word becomes four byte writes, MSB first, and the CPU is held in reset while loading.
module imem_loader #(
  parameter int ADDR_W    = 9,
  parameter int MEM_BYTES = 512,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  imem_loader_if.slave      bus,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err_overflow
);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, FINISH} state_t;

  state_t            state, next_state;
  logic [ADDR_W:0]   cur_addr;
  logic [CNT_W-1:0]  words_left;
  logic [31:0]       word;
  logic [1:0]        byte_idx;
  logic              last_byte, last_word, hit_end;

  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              busy_q, done_q, err_q;

  logic              we_d, busy_d, done_d, err_d;
  logic [7:0]        wdata_d;
  logic [1:0]        wr_idx;
  logic [31:0]       src_word;

  // cur_addr is one bit wider than the memory address, so it can reach MEM_BYTES without wrapping.
  assign last_byte = (byte_idx == 2'd3);
  assign last_word = (words_left == CNT_W'(1));
  assign hit_end   = (cur_addr == (ADDR_W+1)'(MEM_BYTES));

  assign bus.in_ready  = (state == ACCEPT);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = busy_q;
  assign cpu_hold      = busy_q;
  assign done          = done_q;
  assign err_overflow  = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (word_count != '0) ? ACCEPT : FINISH;
      ACCEPT:  if (bus.in_valid) next_state = WRITE;
      WRITE:   if (last_byte) next_state = (last_word || hit_end) ? FINISH : ACCEPT;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they line up with the state they belong to.
  always_comb begin
    wr_idx   = (state == ACCEPT) ? 2'd0 : byte_idx + 2'd1;
    src_word = (state == ACCEPT) ? bus.in_data : word;
    we_d     = (next_state == WRITE);
    busy_d   = (next_state != IDLE);
    done_d   = (next_state == FINISH);
    case (wr_idx)
      2'd0:    wdata_d = src_word[31:24];
      2'd1:    wdata_d = src_word[23:16];
      2'd2:    wdata_d = src_word[15:8];
      default: wdata_d = src_word[7:0];
    endcase
    err_d = err_q;
    if (state == IDLE && start)
      err_d = 1'b0;
    else if (state == WRITE && last_byte && !last_word && hit_end)
      err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cur_addr    <= '0;
      words_left  <= '0;
      word        <= '0;
      byte_idx    <= '0;
    end else begin
      mem_we_q <= we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      if (state == IDLE && start && word_count != '0) begin
        cur_addr   <= {1'b0, base_addr & ~ADDR_W'(3)};
        words_left <= word_count;
      end
      if (state == ACCEPT && bus.in_valid)
        word <= bus.in_data;
      if (we_d) begin
        mem_addr_q  <= cur_addr[ADDR_W-1:0];
        mem_wdata_q <= wdata_d;
        byte_idx    <= wr_idx;
        cur_addr    <= cur_addr + (ADDR_W+1)'(1);
      end
      if (state == WRITE && last_byte)
        words_left <= words_left - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected byte writes and done flags,
// and a monitor pops and compares them whenever the loader writes or finishes.
module tb_imem_loader;
  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [7:0]        word_count = '0;
  logic              busy, cpu_hold, done, err_overflow;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int wr_count = 0;
  logic [16:0] wr_exp[$];
  logic        err_exp[$];
  logic [31:0] src_q[$];
  int          wr_cyc[$];
  logic        hs;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .MEM_BYTES(512), .CNT_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .base_addr(base_addr),
    .word_count(word_count),
    .bus(bus),
    .busy(busy),
    .cpu_hold(cpu_hold),
    .done(done),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic expectWord(input logic [8:0] base, input logic [31:0] w);
    for (int i = 0; i < 4; i++)
      wr_exp.push_back({9'(base + 9'(i)), w[31-8*i -: 8]});
  endtask

  task automatic applyStimulus(input logic [8:0] base, input logic [7:0] count);
    @(posedge clk); #2;
    base_addr  = base;
    word_count = count;
    start      = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic waitWrite(input logic [8:0] addr, input int maxCycles);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(bus.mem_we === 1'b1 && bus.mem_addr === addr) && n < maxCycles);
    checkOutput("write_reached", {bus.mem_we, bus.mem_addr}, {1'b1, addr});
  endtask

  task automatic waitDone(input int maxCycles);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (done !== 1'b1 && n < maxCycles);
    checkOutput("done_seen", done, 1);
    @(negedge clk);
    checkOutput("idle_after_done", {busy, cpu_hold, done}, 0);
  endtask

  // Word source: presents the head of src_q and retires it once the loader has taken it.
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    forever begin
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (hs && src_q.size() > 0) void'(src_q.pop_front());
      bus.in_valid = (src_q.size() > 0);
      bus.in_data  = (src_q.size() > 0) ? src_q[0] : 32'h0;
    end
  end

  initial begin
    logic [16:0] e;
    logic        ee;
    forever begin
      @(negedge clk);
      if (bus.mem_we === 1'b1) begin
        wr_count++;
        wr_cyc.push_back(cyc);
        if (wr_exp.size() == 0) checkOutput("write_expected", wr_exp.size(), 1);
        else begin
          e = wr_exp.pop_front();
          checkOutput("mem_write", {bus.mem_addr, bus.mem_wdata}, e);
        end
      end
      if (done === 1'b1) begin
        if (err_exp.size() == 0) checkOutput("done_expected", err_exp.size(), 1);
        else begin
          ee = err_exp.pop_front();
          checkOutput("done_flags", {err_overflow, busy, cpu_hold}, {ee, 2'b11});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
      {bus.in_ready, bus.mem_we, busy, cpu_hold, done, err_overflow, bus.mem_addr, bus.mem_wdata}, 0);
    reset = 1'b0;

    src_q.push_back(32'h24050000); expectWord(9'h000, 32'h24050000); err_exp.push_back(1'b0);
    applyStimulus(9'h000, 8'd1);
    waitDone(20);

    wr_cyc.delete();
    src_q.push_back(32'h11223344); src_q.push_back(32'h55667788); src_q.push_back(32'h99AABBCC);
    expectWord(9'h010, 32'h11223344); expectWord(9'h014, 32'h55667788); expectWord(9'h018, 32'h99AABBCC);
    err_exp.push_back(1'b0);
    applyStimulus(9'h010, 8'd3);
    waitDone(40);
    checkOutput("b2b_write_count", wr_cyc.size(), 12);
    if (wr_cyc.size() == 12)
      for (int k = 0; k < 12; k++)
        checkOutput("b2b_timing", wr_cyc[k] - wr_cyc[0], (k / 4) * 5 + k % 4);

    src_q.push_back(32'hCAFEF00D);
    expectWord(9'h020, 32'hCAFEF00D); expectWord(9'h024, 32'h0F1E2D3C); err_exp.push_back(1'b0);
    applyStimulus(9'h020, 8'd2);
    waitWrite(9'h023, 20);
    repeat (7) begin
      @(negedge clk);
      checkOutput("stall_accept", {bus.in_ready, bus.mem_we, busy}, 3'b101);
    end
    src_q.push_back(32'h0F1E2D3C);
    waitDone(30);

    src_q.push_back(32'h89ABCDEF); expectWord(9'h004, 32'h89ABCDEF); err_exp.push_back(1'b0);
    applyStimulus(9'h007, 8'd1);
    waitDone(20);

    n0 = wr_count;
    err_exp.push_back(1'b0);
    applyStimulus(9'h055, 8'd0);
    waitDone(3);
    checkOutput("zero_count_writes", wr_count - n0, 0);

    src_q.push_back(32'hA1B2C3D4); src_q.push_back(32'h0BADF00D);
    expectWord(9'h1FC, 32'hA1B2C3D4); err_exp.push_back(1'b1);
    applyStimulus(9'h1FC, 8'd2);
    waitDone(30);
    checkOutput("overflow_word_left", src_q.size(), 1);
    checkOutput("overflow_sticky", err_overflow, 1);
    src_q.delete();

    src_q.push_back(32'h13579BDF); expectWord(9'h1FC, 32'h13579BDF); err_exp.push_back(1'b0);
    applyStimulus(9'h1FC, 8'd1);
    waitDone(20);

    src_q.push_back(32'hDEADBEEF);
    wr_exp.push_back({9'h040, 8'hDE}); wr_exp.push_back({9'h041, 8'hAD}); wr_exp.push_back({9'h042, 8'hBE});
    applyStimulus(9'h040, 8'd1);
    waitWrite(9'h042, 20);
    #1 reset = 1'b1;
    #1 checkOutput("reset_mid_write",
      {bus.in_ready, bus.mem_we, busy, cpu_hold, done, err_overflow, bus.mem_addr, bus.mem_wdata}, 0);
    @(negedge clk);
    reset = 1'b0;

    src_q.push_back(32'h24050000); expectWord(9'h000, 32'h24050000); err_exp.push_back(1'b0);
    applyStimulus(9'h000, 8'd1);
    waitWrite(9'h000, 10);
    @(posedge clk); #2;
    base_addr = 9'h100; word_count = 8'd5; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    waitDone(20);
    repeat (4) begin
      @(negedge clk);
      checkOutput("start_while_busy_ignored", {busy, bus.mem_we}, 0);
    end

    checkOutput("writes_all_seen", wr_exp.size(), 0);
    checkOutput("dones_all_seen", err_exp.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
